fetch_sequencer: RTL
====================

# fetch_sequencer

Program-counter owner and instruction-fetch sequencer for the KGP-miniRISC core. Holds the architectural PC, issues word-addressed fetch requests to instruction memory over a req/ack handshake, and presents the fetched instruction with its PC to decode and to the jump unit's `PCin`. On instruction completion it loads the jump unit's `next_address` into the PC and starts the next fetch.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `TIMEOUT_CYCLES`, default 255: fetch watchdog limit; used only with `FETCH_TIMEOUT_EN`; range 1..65535.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request; held high until ack.
- `imem_addr` out 32: word address of the fetch; equals PC; stable while `imem_req` is high.
- `imem_ack` in 1: memory has `imem_rdata` valid this cycle.
- `imem_rdata` in 32: fetched instruction word.
- `instr` out 32: latched instruction.
- `instr_pc` out 32: PC of `instr`; drives the jump unit's `PCin`.
- `instr_valid` out 1: `instr`/`instr_pc` valid for execution.
- `exec_done` in 1: core has finished the current instruction; `next_address` is valid.
- `next_address` in 32: resolved next PC from the jump unit.
- `halt_in` in 1: current instruction is a halt; sampled with `exec_done`.
- `halted` out 1: sequencer stopped.
- `retired` out 32: count of completed instructions.
- `fault` out 1: fetch timeout occurred; constant 0 without `FETCH_TIMEOUT_EN`.

## Operation
- States: `S_RESET`, `S_FETCH`, `S_EXEC`, `S_HALT`.
- `S_RESET` (entered on `rst`): `imem_req`=0; `imem_ack` is ignored, so a stale ack is discarded. Unconditional move to `S_FETCH` next cycle.
- `S_FETCH`: `imem_req`=1, `imem_addr`=PC.
  - On `imem_ack`: `instr`<=`imem_rdata`, `instr_pc`<=PC, `instr_valid`<=1, go to `S_EXEC`.
- `S_EXEC`: `imem_req`=0; `instr_valid`=1. Waits indefinitely for `exec_done`.
  - On `exec_done` with `halt_in`=0: PC<=`next_address`, `retired`+=1, `instr_valid`<=0, go to `S_FETCH`.
  - On `exec_done` with `halt_in`=1: PC is unchanged, `retired`+=1, `instr_valid`<=0, `halted`<=1, go to `S_HALT`.
- `S_HALT`: terminal. All requests stay low; only `rst` exits.
- `imem_ack` outside `S_FETCH` is ignored. `exec_done` outside `S_EXEC` is ignored.
- `retired` wraps modulo 2^32. `next_address` is loaded verbatim, with no alignment or range check.

## Timing
- Reset values:
  - PC and `imem_addr` = `RESET_PC`.
  - `instr`, `instr_pc`, `retired` = 0.
  - `imem_req`, `instr_valid`, `halted`, `fault` = 0.
  - State = `S_RESET`.
- First `imem_req` rises one cycle after `rst` deasserts.
- Minimum 2 cycles per instruction: ack in the first `S_FETCH` cycle, then `exec_done` in the first `S_EXEC` cycle.
- `instr_valid` rises the cycle after the ack and falls the cycle after `exec_done`.
- The new PC appears on `imem_addr` the cycle after `exec_done`.
- `rst` overrides everything in any state, mid-fetch or mid-exec: reset values apply the next cycle and the fetch is abandoned.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to `S_FETCH` and increments each `S_FETCH` cycle without ack.
  - When it reaches `TIMEOUT_CYCLES`: `fault`<=1, `halted`<=1, go to `S_HALT`, `imem_req` drops next cycle.
  - An ack in the same cycle as the limit wins: normal transition, no fault.
- `FETCH_TIMEOUT_EN` undefined: no counter; `fault` tied 0; the sequencer waits for ack forever.

## Structure
- Shared miniRISC package holds:
  - the state enum (2-bit encoding `S_RESET`=0, `S_FETCH`=1, `S_EXEC`=2, `S_HALT`=3);
  - the 32-bit word/address width constant;
  - the default `RESET_PC`.
- One sub-module, `fetch_watchdog`: the timeout counter, instantiated only under `FETCH_TIMEOUT_EN`.
- The top level holds the state machine, PC, instruction latch and retire counter.

## Test plan
- Reset, then immediate ack with rdata=32'hA5A5_0001, then `exec_done` with next_address=32'h10:
  - `imem_addr`=0 first;
  - `instr`=32'hA5A5_0001 and `instr_pc`=0;
  - next fetch at 32'h10;
  - `retired`=1.
- Ack delayed 5 cycles: `imem_req` stays high and `imem_addr` stable for 6 cycles; `instr_valid` never rises early.
- `exec_done`+`halt_in` at PC=32'h7:
  - `halted`=1, PC stays 32'h7, no further `imem_req`;
  - an ack injected in `S_HALT` is ignored.
- `rst` asserted mid-`S_EXEC` with an ack pulsed in the cycle after `rst` deasserts:
  - ack is ignored (`S_RESET`);
  - `instr_valid`=0, `retired`=0;
  - fetch restarts at `RESET_PC`.
- With `FETCH_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, no ack: `fault`=1 and `halted`=1 after 4 `S_FETCH` cycles; with ack on cycle 4, no fault.
- `retired` preloaded near 32'hFFFF_FFFF (force) plus one retirement: wraps to 0.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared miniRISC types and constants for the fetch sequencer
package fetch_sequencer_pkg;

   localparam int WORD_W = 32;

   localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_RESET = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

endpackage

// File: rtl/fetch_watchdog.sv
// rtl/fetch_watchdog.sv - fetch timeout counter; flags the cycle a fetch runs out of budget
module fetch_watchdog #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic ack,
   output logic expire
);

   localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] count;

   // Held at zero outside a fetch so every fetch starts with a full budget.
   always_ff @(posedge clk) begin
      if (rst || !active) begin
         count <= '0;
      end else if (!ack) begin
         count <= count + 16'd1;
      end
   end

   // An ack arriving on the final allowed cycle takes priority over the timeout.
   assign expire = active && !ack && (count == LAST_WAIT);

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and instruction-fetch sequencer for KGP-miniRISC
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC       = DEFAULT_RESET_PC,
   parameter int                TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [WORD_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [WORD_W-1:0] imem_rdata,
   output logic [WORD_W-1:0] instr,
   output logic [WORD_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              exec_done,
   input  logic [WORD_W-1:0] next_address,
   input  logic              halt_in,
   output logic              halted,
   output logic [WORD_W-1:0] retired,
   output logic              fault
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("fetch_sequencer: TIMEOUT_CYCLES out of range 1..65535");
   end

   state_t            state;
   state_t            next_state;
   logic [WORD_W-1:0] pc;
   logic [WORD_W-1:0] instr_q;
   logic [WORD_W-1:0] instr_pc_q;
   logic [WORD_W-1:0] retired_q;
   logic              timeout;

`ifdef FETCH_TIMEOUT_EN
   logic fault_q;

   fetch_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .active (state == S_FETCH),
      .ack    (imem_ack),
      .expire (timeout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         fault_q <= 1'b0;
      end else if (timeout) begin
         fault_q <= 1'b1;
      end
   end

   assign fault = fault_q;
`else
   assign timeout = 1'b0;
   assign fault   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_RESET;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_RESET: next_state = S_FETCH;
         S_FETCH: begin
            if (imem_ack) begin
               next_state = S_EXEC;
            end else if (timeout) begin
               next_state = S_HALT;
            end
         end
         S_EXEC: begin
            if (exec_done) begin
               next_state = halt_in ? S_HALT : S_FETCH;
            end
         end
         default: next_state = S_HALT;
      endcase
   end

   always_comb begin
      imem_req    = (state == S_FETCH);
      instr_valid = (state == S_EXEC);
      halted      = (state == S_HALT);
   end

   // A halting instruction retires but leaves the PC pointing at itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc         <= RESET_PC;
         instr_q    <= '0;
         instr_pc_q <= '0;
         retired_q  <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (imem_ack) begin
                  instr_q    <= imem_rdata;
                  instr_pc_q <= pc;
               end
            end
            S_EXEC: begin
               if (exec_done) begin
                  retired_q <= retired_q + 32'd1;
                  if (!halt_in) begin
                     pc <= next_address;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign imem_addr = pc;
   assign instr     = instr_q;
   assign instr_pc  = instr_pc_q;
   assign retired   = retired_q;

endmodule
